ytile_row_storer: RTL and testbench

Write-side counterpart of the X-tile row loader: accepts one computed output row of N words through a valid/ready handshake, buffers it, and drains it column by column into a k/n-addressed SRAM write port. Sits between the MAC array's row output and the result SRAM. A shared-port grant lets a CPU/DRAM path take priority on the SRAM, so the storer stalls whenever the grant is low.

---
 rtl/ytile_row_storer.sv | 111 +++++++++++
 tb/tb_ytile_row_storer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ytile_row_storer.sv
// ytile_row_storer: buffers one N-word output row and drains its masked columns into a k/n-addressed SRAM write port.
module ytile_row_storer #(
  parameter int N      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int N_W    = (N <= 1) ? 1 : $clog2(N),
  parameter int K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [K_W-1:0]        k_idx,
  input  logic [N-1:0]          col_mask,
  input  logic [N*DATA_W-1:0]   row_flat,
  output logic                  y_en,
  output logic                  y_we,
  output logic                  y_re,
  output logic [K_W-1:0]        y_k,
  output logic [N_W-1:0]        y_n,
  output logic [DATA_W-1:0]     y_wdata,
  output logic [BYTE_W-1:0]     y_wmask,
  input  logic                  y_gnt,
  output logic                  busy,
  output logic                  row_done,
  output logic                  err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [N-1:0]      mask_q, mask_d;
  logic [DATA_W-1:0] buf_q [N];
  logic [DATA_W-1:0] buf_d [N];
  logic [N_W-1:0]    cur_q, cur_d;
  logic              err_q, err_d;
  logic [N-1:0]      above;
  logic              hs, bad_k;

  function automatic logic [N_W-1:0] low_bit(input logic [N-1:0] m);
    low_bit = '0;
    for (int i = N - 1; i >= 0; i--) if (m[i]) low_bit = N_W'(i);
  endfunction

  // Columns still pending after the current one; masked-out columns never appear here.
  always_comb begin
    for (int i = 0; i < N; i++) above[i] = mask_q[i] && (i > int'(cur_q));
  end

  assign hs    = row_valid && row_ready;
  assign bad_k = {1'b0, k_idx} >= (K_W + 1)'(KMAX);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mask_d  = mask_q;
    buf_d   = buf_q;
    cur_d   = cur_q;
    err_d   = 1'b0;
    if (state_q == IDLE && hs) begin
      if (bad_k) begin
        err_d = 1'b1;
      end else begin
        k_d     = k_idx;
        mask_d  = col_mask;
        cur_d   = low_bit(col_mask);
        state_d = |col_mask ? WRITE : DONE;
        for (int i = 0; i < N; i++) buf_d[i] = row_flat[i*DATA_W +: DATA_W];
      end
    end else if (state_q == WRITE && y_gnt) begin
      cur_d   = low_bit(above);
      state_d = |above ? WRITE : DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      mask_q  <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
    end
  end

  // Address/data are forced to zero whenever no write is requested.
  assign row_ready = state_q == IDLE;
  assign y_en      = state_q == WRITE;
  assign y_we      = y_en;
  assign y_re      = 1'b0;
  assign y_k       = y_en ? k_q : '0;
  assign y_n       = y_en ? cur_q : '0;
  assign y_wdata   = y_en ? buf_q[cur_q] : '0;
  assign y_wmask   = {BYTE_W{y_en}};
  assign busy      = state_q != IDLE;
  assign row_done  = state_q == DONE;
  assign err       = err_q;
endmodule

// File: tb/tb_ytile_row_storer.sv
// tb_ytile_row_storer: randomized bench with an SRAM model and a column-queue reference for ytile_row_storer.
module tb_ytile_row_storer;
  localparam int N = 8, KMAX = 1000, DW = 32, KW = 10, NW = 3, BW = 4;

  logic clk = 0, rst = 1, row_valid = 0, y_gnt = 1;
  logic [KW-1:0] k_idx = '0;
  logic [N-1:0] col_mask = '0;
  logic [N*DW-1:0] row_flat = '0;
  logic row_ready, y_en, y_we, y_re, busy, row_done, err;
  logic [KW-1:0] y_k;
  logic [NW-1:0] y_n;
  logic [DW-1:0] y_wdata;
  logic [BW-1:0] y_wmask;
  logic cpu_we = 0;
  logic [KW-1:0] cpu_k = '0;
  logic [NW-1:0] cpu_n = '0;
  logic [DW-1:0] cpu_d = '0;
  logic [DW-1:0] sram [KMAX][N];
  logic [DW-1:0] exp_mem [KMAX][N];
  int cyc = 0, total = 0, bad = 0;

  ytile_row_storer #(.N(N), .KMAX(KMAX), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .row_valid(row_valid), .row_ready(row_ready), .k_idx(k_idx),
    .col_mask(col_mask), .row_flat(row_flat), .y_en(y_en), .y_we(y_we), .y_re(y_re),
    .y_k(y_k), .y_n(y_n), .y_wdata(y_wdata), .y_wmask(y_wmask), .y_gnt(y_gnt),
    .busy(busy), .row_done(row_done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result SRAM: the storer wins when granted, otherwise the CPU path may write.
  always @(posedge clk)
    if (y_en && y_gnt) sram[y_k][y_n] <= y_wdata;
    else if (cpu_we) sram[cpu_k][cpu_n] <= cpu_d;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] rnd_row();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic preload(input logic [KW-1:0] k);
    for (int n = 0; n < N; n++) begin
      cpu_we = 1; cpu_k = k; cpu_n = NW'(n); cpu_d = $urandom;
      exp_mem[k][n] = cpu_d;
      @(posedge clk); #1;
    end
    cpu_we = 0;
  endtask

  task automatic check_row(input logic [KW-1:0] k);
    for (int n = 0; n < N; n++) chk($sformatf("mem k%0d n%0d", k, n), sram[k][n], exp_mem[k][n]);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " y_en"}, y_en, 0); chk({tag, " y_we"}, y_we, 0); chk({tag, " y_re"}, y_re, 0);
    chk({tag, " y_k"}, y_k, 0); chk({tag, " y_n"}, y_n, 0); chk({tag, " y_wdata"}, y_wdata, 0);
    chk({tag, " y_wmask"}, y_wmask, 0); chk({tag, " row_ready"}, row_ready, 1);
    chk({tag, " busy"}, busy, 0); chk({tag, " row_done"}, row_done, 0); chk({tag, " err"}, err, 0);
  endtask

  // lo<0: random grant; else grant is low for cycles lo..hi after the handshake (CPU writes n=1 at cycle lo).
  task automatic run_row(input logic [KW-1:0] k, input logic [N-1:0] m, input logic [N*DW-1:0] d,
                         input int lo, input int hi, input bit keep, input logic [KW-1:0] nk,
                         input logic [N*DW-1:0] nd, output int hs);
    int q[$];
    int w, t;
    bit done;
    logic [DW-1:0] cw;
    for (int n = 0; n < N; n++) if (m[n]) q.push_back(n);
    row_valid = 1; k_idx = k; col_mask = m; row_flat = d;
    for (w = 0; w < 50 && !row_ready; w++) @(negedge clk);
    chk("ready wait", row_ready, 1);
    @(posedge clk); #1;
    hs = cyc;
    row_valid = keep; k_idx = nk; row_flat = nd; col_mask = keep ? m : ~m;
    done = 0; cw = '0;
    for (t = 1; t < 100 && !done; t++) begin
      y_gnt = (lo < 0) ? ($urandom_range(0, 3) != 0) : !(t >= lo && t <= hi);
      cpu_we = (lo > 0 && t == lo);
      if (cpu_we) begin cpu_k = k; cpu_n = 1; cpu_d = $urandom; end
      @(negedge clk);
      if (q.size() > 0) begin
        cw = d[q[0]*DW +: DW];
        chk("y_en", y_en, 1); chk("y_we", y_we, 1); chk("y_re", y_re, 0);
        chk("y_k", y_k, k); chk("y_n", y_n, q[0]); chk("y_wdata", y_wdata, cw);
        chk("y_wmask", y_wmask, 4'hf); chk("ready in write", row_ready, 0);
        chk("busy", busy, 1); chk("row_done early", row_done, 0);
      end else begin
        chk("row_done", row_done, 1); chk("y_en in done", y_en, 0); chk("busy in done", busy, 1);
        done = 1;
      end
      @(posedge clk); #1;
      if (cpu_we) exp_mem[k][1] = cpu_d;
      cpu_we = 0;
      if (!done && y_gnt) begin
        exp_mem[k][q[0]] = cw;
        void'(q.pop_front());
      end
    end
    chk("row timeout", done, 1);
    y_gnt = 1;
    @(negedge clk);
    chk("ready after", row_ready, 1); chk("done pulse", row_done, 0); chk("busy after", busy, 0);
    check_row(k);
  endtask

  initial begin
    logic [N*DW-1:0] d, d2;
    logic [KW-1:0] k;
    logic [N-1:0] m;
    int h1, h2, w;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst = 0;

    preload(5);
    for (int n = 0; n < N; n++) d[n*DW +: DW] = 32'h1000 + n;
    run_row(5, 8'hff, d, 0, -1, 0, 0, rnd_row(), h1);

    preload(7);
    run_row(7, 8'b1010_0100, rnd_row(), 0, -1, 0, 0, rnd_row(), h1);

    preload(5);
    run_row(5, 8'hff, rnd_row(), 3, 5, 0, 0, rnd_row(), h1);

    preload(3);
    run_row(3, 8'h00, rnd_row(), 0, -1, 0, 0, rnd_row(), h1);

    row_valid = 1; k_idx = 10'd1001; col_mask = 8'hff; row_flat = rnd_row();
    for (w = 0; w < 50 && !row_ready; w++) @(negedge clk);
    @(posedge clk); #1 row_valid = 0;
    @(negedge clk);
    chk("err pulse", err, 1); chk("err ready", row_ready, 1); chk("err y_en", y_en, 0); chk("err busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err cleared", err, 0); chk("err y_en later", y_en, 0);

    preload(1); preload(2);
    d = rnd_row(); d2 = rnd_row();
    run_row(1, 8'hff, d, 0, -1, 1, 2, d2, h1);
    run_row(2, 8'hff, d2, 0, -1, 0, 0, rnd_row(), h2);
    chk("b2b spacing", h2 - h1, N + 2);

    preload(4);
    d = rnd_row();
    row_valid = 1; k_idx = 4; col_mask = 8'hff; row_flat = d; y_gnt = 1;
    for (w = 0; w < 50 && !row_ready; w++) @(negedge clk);
    @(posedge clk); #1 row_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) exp_mem[4][n] = d[n*DW +: DW];
    @(negedge clk);
    chk("pre-reset y_en", y_en, 1); chk("pre-reset y_n", y_n, 3);
    #1 rst = 1;
    #1 check_idle_outputs("async rst");
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_row(4);
    check_idle_outputs("after rst");

    preload(6);
    run_row(6, 8'hff, rnd_row(), 0, -1, 0, 0, rnd_row(), h1);

    repeat (12) begin
      k = KW'($urandom_range(0, KMAX - 1));
      m = N'($urandom);
      preload(k);
      run_row(k, m, rnd_row(), -1, 0, 0, 0, rnd_row(), h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
